// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin and CPU-side handshake bundle for spi_slave
interface spi_slave_if;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_pending;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       overrun;
   logic       busy;

   modport slave (
      input  sclk, cs_n, mosi, tx_data, tx_load, rx_ack,
      output miso, miso_oe, tx_pending, rx_data, rx_valid, overrun, busy
   );

   modport master (
      output sclk, cs_n, mosi, tx_data, tx_load, rx_ack,
      input  miso, miso_oe, tx_pending, rx_data, rx_valid, overrun, busy
   );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder on raw_clk; SPI_SLAVE_RX_FIFO_EN selects an rx FIFO
module spi_slave #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEFAULT_TX  = 8'hff,
   parameter int         FIFO_DEPTH  = 4
) (
   input  logic         raw_clk,
   input  logic         reset,
   spi_slave_if.slave   bus
);
   typedef enum logic {ST_IDLE, ST_SELECTED} state_t;

   state_t     r_state, w_state_next;
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic [2:0] r_bit_count;
   logic [7:0] r_tx_shift, r_rx_shift, r_tx_buffer;
   logic       r_tx_pending;
   logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;
   logic       w_byte_start, w_rise_en, w_fall_en, w_cs_leave, w_byte_done;
   logic [7:0] w_rx_byte, w_tx_next;

   always_ff @(posedge raw_clk) begin
      if (reset) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      end
   end

   always_comb begin
      w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
      w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
      w_cs_fall   = ~r_cs_sync[SYNC_STAGES-2] & r_cs_sync[SYNC_STAGES-1];
      w_cs_rise   = r_cs_sync[SYNC_STAGES-2] & ~r_cs_sync[SYNC_STAGES-1];
      w_mosi      = r_mosi_sync[SYNC_STAGES-1];
      w_rx_byte   = {r_rx_shift[6:0], w_mosi};
      // A strobe landing on the reload cycle wins over the stale buffer
      w_tx_next   = bus.tx_load ? bus.tx_data : (r_tx_pending ? r_tx_buffer : DEFAULT_TX);
   end

   always_ff @(posedge raw_clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_byte_start = 1'b0;
      w_rise_en    = 1'b0;
      w_fall_en    = 1'b0;
      w_cs_leave   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_next = ST_SELECTED;
               w_byte_start = 1'b1;
               w_rise_en    = w_sclk_rise;
            end
         end
         ST_SELECTED: begin
            if (w_cs_rise) begin
               w_state_next = ST_IDLE;
               w_cs_leave   = 1'b1;
            end else begin
               w_rise_en = w_sclk_rise;
               w_fall_en = w_sclk_fall && (r_bit_count != 3'd0);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      w_byte_done = w_rise_en && (r_bit_count == 3'd7);
      if (w_byte_done) w_byte_start = 1'b1;
   end

   always_ff @(posedge raw_clk) begin
      if (reset) begin
         r_bit_count  <= 3'd0;
         r_tx_shift   <= 8'h00;
         r_rx_shift   <= 8'h00;
         r_tx_buffer  <= DEFAULT_TX;
         r_tx_pending <= 1'b0;
      end else begin
         if (bus.tx_load) r_tx_buffer <= bus.tx_data;
         if (w_byte_start)     r_tx_pending <= 1'b0;
         else if (bus.tx_load) r_tx_pending <= 1'b1;
         if (w_cs_leave) begin
            r_bit_count <= 3'd0;
            r_rx_shift  <= 8'h00;
         end else if (w_rise_en) begin
            r_rx_shift  <= w_rx_byte;
            r_bit_count <= r_bit_count + 3'd1;
         end
         if (w_byte_start)   r_tx_shift <= w_tx_next;
         else if (w_fall_en) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
   end

   assign bus.miso       = (r_state == ST_SELECTED) ? r_tx_shift[7] : 1'b0;
   assign bus.miso_oe    = (r_state == ST_SELECTED);
   assign bus.busy       = (r_state == ST_SELECTED) && (r_bit_count != 3'd0);
   assign bus.tx_pending = r_tx_pending;

`ifdef SPI_SLAVE_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic        r_overrun;
   logic        w_empty, w_full, w_pop, w_push, w_drop;

   always_comb begin
      w_empty = (r_wr_ptr == r_rd_ptr);
      w_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
      w_pop   = bus.rx_ack && !w_empty;
      // A pop in the same cycle frees the slot a full push needs
      w_push  = w_byte_done && (!w_full || w_pop);
      w_drop  = w_byte_done && w_full && !w_pop;
   end

   always_ff @(posedge raw_clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_rx_byte;
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         if (w_drop)                        r_overrun <= 1'b1;
         else if (bus.rx_ack && r_overrun)  r_overrun <= 1'b0;
      end
   end

   assign bus.rx_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign bus.rx_valid = !w_empty;
   assign bus.overrun  = r_overrun;
`else
   logic [7:0] r_rx_data;
   logic       r_rx_valid, r_overrun;
   logic       w_accept, w_drop;

   always_comb begin
      w_accept = w_byte_done && (!r_rx_valid || bus.rx_ack);
      w_drop   = w_byte_done && r_rx_valid && !bus.rx_ack;
   end

   always_ff @(posedge raw_clk) begin
      if (reset) begin
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rx_data  <= w_rx_byte;
            r_rx_valid <= 1'b1;
         end else if (bus.rx_ack) begin
            r_rx_valid <= 1'b0;
         end
         if (w_drop)                        r_overrun <= 1'b1;
         else if (bus.rx_ack && r_overrun)  r_overrun <= 1'b0;
      end
   end

   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.overrun  = r_overrun;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave acting as SPI master at raw_clk/8
module tb_spi_slave;
   logic raw_clk;
   logic reset;
   int   checks;
   int   errors;

   spi_slave_if bus_if ();

   spi_slave dut (
      .raw_clk (raw_clk),
      .reset   (reset),
      .bus     (bus_if.slave)
   );

   initial raw_clk = 1'b0;
   always #5 raw_clk = ~raw_clk;

   // All driving happens on negedge-aligned times; bits last 80 ns (8 raw_clk cycles)
   task automatic send_bits(input logic [7:0] tx, input int nbits, input int load_bit,
                            input logic [7:0] load_val, output logic [7:0] rx, output int lat);
      rx  = 8'h00;
      lat = -1;
      for (int i = 0; i < nbits; i++) begin
         bus_if.mosi = tx[7-i];
         if (i == load_bit) begin
            bus_if.tx_data = load_val;
            bus_if.tx_load = 1'b1;
            #10;
            bus_if.tx_load = 1'b0;
            #30;
         end else begin
            #40;
         end
         bus_if.sclk = 1'b1;
         rx[7-i] = bus_if.miso;
         if (i == 7) begin
            for (int k = 1; k <= 4; k++) begin
               #10;
               if (lat < 0 && bus_if.rx_valid === 1'b1) lat = k;
            end
         end else begin
            #40;
         end
         bus_if.sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      bus_if.cs_n = 1'b0;
      #40;
   endtask

   task automatic cs_high();
      #40;
      bus_if.cs_n = 1'b1;
      #80;
   endtask

   task automatic pulse_ack();
      bus_if.rx_ack = 1'b1;
      #10;
      bus_if.rx_ack = 1'b0;
      #10;
   endtask

   task automatic test_reset();
      bus_if.sclk = 1'b0; bus_if.cs_n = 1'b1; bus_if.mosi = 1'b0;
      bus_if.tx_data = 8'h00; bus_if.tx_load = 1'b0; bus_if.rx_ack = 1'b0;
      reset = 1'b1;
      @(negedge raw_clk);
      #40;
      reset = 1'b0;
      #20;
      checks++; if (bus_if.miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", bus_if.miso); end
      checks++; if (bus_if.miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe got %b want 0", bus_if.miso_oe); end
      checks++; if (bus_if.tx_pending !== 1'b0) begin errors++; $display("FAIL reset_tx_pending got %b want 0", bus_if.tx_pending); end
      checks++; if (bus_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", bus_if.rx_data); end
      checks++; if (bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", bus_if.rx_valid); end
      checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus_if.overrun); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
   endtask

   task automatic test_loaded_byte();
      logic [7:0] rx;
      int lat;
      bus_if.tx_data = 8'hA5;
      bus_if.tx_load = 1'b1;
      #10;
      bus_if.tx_load = 1'b0;
      #10;
      checks++; if (bus_if.tx_pending !== 1'b1) begin errors++; $display("FAIL load_pending got %b want 1", bus_if.tx_pending); end
      cs_low();
      send_bits(8'h3C, 8, -1, 8'h00, rx, lat);
      cs_high();
      checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL load_miso_byte got %h want a5", rx); end
      checks++; if (lat < 1 || lat > 4) begin errors++; $display("FAIL load_latency got %0d want 1..4", lat); end
      checks++; if (bus_if.rx_data !== 8'h3C) begin errors++; $display("FAIL load_rx_data got %h want 3c", bus_if.rx_data); end
      checks++; if (bus_if.rx_valid !== 1'b1) begin errors++; $display("FAIL load_rx_valid got %b want 1", bus_if.rx_valid); end
      checks++; if (bus_if.tx_pending !== 1'b0) begin errors++; $display("FAIL load_pending_clear got %b want 0", bus_if.tx_pending); end
      pulse_ack();
      checks++; if (bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL load_ack got %b want 0", bus_if.rx_valid); end
   endtask

   task automatic test_default_tx();
      logic [7:0] rx;
      int lat;
      cs_low();
      send_bits(8'h81, 8, -1, 8'h00, rx, lat);
      cs_high();
      checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL default_miso_byte got %h want ff", rx); end
      checks++; if (bus_if.rx_data !== 8'h81) begin errors++; $display("FAIL default_rx_data got %h want 81", bus_if.rx_data); end
      pulse_ack();
   endtask

`ifndef SPI_SLAVE_RX_FIFO_EN
   task automatic test_back_to_back();
      logic [7:0] rx1, rx2;
      int lat;
      cs_low();
      send_bits(8'h11, 8, -1, 8'h00, rx1, lat);
      send_bits(8'h22, 8, -1, 8'h00, rx2, lat);
      cs_high();
      checks++; if (rx2 !== 8'hFF) begin errors++; $display("FAIL b2b_miso_byte2 got %h want ff", rx2); end
      checks++; if (bus_if.rx_data !== 8'h11) begin errors++; $display("FAIL b2b_rx_data got %h want 11", bus_if.rx_data); end
      checks++; if (bus_if.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", bus_if.overrun); end
      pulse_ack();
      checks++; if (bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack_valid got %b want 0", bus_if.rx_valid); end
      checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("FAIL b2b_ack_overrun got %b want 0", bus_if.overrun); end
   endtask
`else
   task automatic test_fifo();
      logic [7:0] rx;
      int lat;
      cs_low();
      for (int b = 1; b <= 5; b++) send_bits(8'(b), 8, -1, 8'h00, rx, lat);
      cs_high();
      checks++; if (bus_if.overrun !== 1'b1) begin errors++; $display("FAIL fifo_overrun got %b want 1", bus_if.overrun); end
      for (int i = 1; i <= 4; i++) begin
         checks++; if (bus_if.rx_data !== 8'(i)) begin errors++; $display("FAIL fifo_head%0d got %h want %h", i, bus_if.rx_data, 8'(i)); end
         pulse_ack();
         if (i == 1) begin
            checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("FAIL fifo_overrun_clear got %b want 0", bus_if.overrun); end
         end
      end
      checks++; if (bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty got %b want 0", bus_if.rx_valid); end
   endtask
`endif

   task automatic test_abort();
      logic [7:0] rx;
      int lat;
      cs_low();
      send_bits(8'hF8, 5, -1, 8'h00, rx, lat);
      #40;
      checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid got %b want 1", bus_if.busy); end
      checks++; if (bus_if.miso_oe !== 1'b1) begin errors++; $display("FAIL abort_oe_mid got %b want 1", bus_if.miso_oe); end
      bus_if.cs_n = 1'b1;
      #80;
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus_if.busy); end
      checks++; if (bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_rx_valid got %b want 0", bus_if.rx_valid); end
      checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun got %b want 0", bus_if.overrun); end
      checks++; if (bus_if.miso_oe !== 1'b0 || bus_if.miso !== 1'b0) begin errors++; $display("FAIL abort_miso got oe=%b miso=%b want 0 0", bus_if.miso_oe, bus_if.miso); end
      cs_low();
      send_bits(8'h5A, 8, -1, 8'h00, rx, lat);
      cs_high();
      checks++; if (bus_if.rx_data !== 8'h5A) begin errors++; $display("FAIL abort_next_byte got %h want 5a", bus_if.rx_data); end
      pulse_ack();
   endtask

   task automatic test_midbyte_load();
      logic [7:0] rx1, rx2;
      int lat;
      bus_if.tx_data = 8'h00;
      bus_if.tx_load = 1'b1;
      #10;
      bus_if.tx_load = 1'b0;
      #10;
      cs_low();
      send_bits(8'h00, 8, 2, 8'hC3, rx1, lat);
      send_bits(8'h00, 8, -1, 8'h00, rx2, lat);
      cs_high();
      checks++; if (rx1 !== 8'h00) begin errors++; $display("FAIL midload_byte1 got %h want 00", rx1); end
      checks++; if (rx2 !== 8'hC3) begin errors++; $display("FAIL midload_byte2 got %h want c3", rx2); end
      checks++; if (bus_if.tx_pending !== 1'b0) begin errors++; $display("FAIL midload_pending got %b want 0", bus_if.tx_pending); end
      pulse_ack();
      pulse_ack();
      checks++; if (bus_if.rx_valid !== 1'b0 || bus_if.overrun !== 1'b0) begin errors++; $display("FAIL midload_drain got valid=%b ovr=%b want 0 0", bus_if.rx_valid, bus_if.overrun); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_loaded_byte();
      test_default_tx();
`ifndef SPI_SLAVE_RX_FIFO_EN
      test_back_to_back();
`else
      test_fifo();
`endif
      test_abort();
      test_midbyte_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
